// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared frame state, default constants and checksum helper
package uart_frame_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } frame_state_t;

    localparam logic [7:0] SYNC_BYTE_DEF     = 8'hA5;
    localparam int         PAYLOAD_BYTES_DEF = 4;

    // Running XOR checksum step; the transmit framer uses the same fold.
    function automatic logic [7:0] xor_update(input logic [7:0] acc, input logic [7:0] data_byte);
        return acc ^ data_byte;
    endfunction

endpackage

// File: rtl/uart_frame_rx.sv
// rtl/uart_frame_rx.sv - RX frame decoder (sync, payload, XOR checksum); optional timeout via UART_FRAME_RX_TIMEOUT_EN
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter int         PAYLOAD_BYTES = PAYLOAD_BYTES_DEF,
    parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CYC   = 100000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx_empty,
    input  logic [7:0]                 r_data,
    output logic                       rd_uart,
    output logic [8*PAYLOAD_BYTES-1:0] frame_data,
    output logic                       frame_valid,
    output logic                       chk_err,
    output logic                       busy
);

    localparam int IDX_W = $clog2(PAYLOAD_BYTES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);

    // Reject nonsensical configurations at elaboration.
    if (PAYLOAD_BYTES < 1 || PAYLOAD_BYTES > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("uart_frame_rx: PAYLOAD_BYTES must be 1..8 and TIMEOUT_CYC >= 1");
    end

    frame_state_t                 state;
    logic [IDX_W-1:0]             idx;
    logic [7:0]                   csum;
    logic [8*PAYLOAD_BYTES-1:0]   shadow;
    logic                         consume;
    logic                         tmo_fire;

    // The FIFO is never back-pressured: pop whenever a byte is waiting.
    always_comb begin
        rd_uart = !rx_empty && !rst;
        consume = rd_uart;
    end

`ifdef UART_FRAME_RX_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt;

    // Timeout fires on the idle cycle that would bring the count to TIMEOUT_CYC.
    always_comb begin
        tmo_fire = (state != IDLE) && !consume && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
    end

    // Count idle cycles mid-frame; any consumed byte or IDLE clears it.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE || consume || tmo_fire) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end
`else
    // Without the timeout the FSM waits indefinitely mid-frame.
    always_comb begin
        tmo_fire = 1'b0;
    end
`endif

    // Frame FSM: sync hunt, payload collection, checksum compare; strobes registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            csum        <= '0;
            shadow      <= '0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            chk_err     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            chk_err     <= 1'b0;
            if (consume) begin
                case (state)
                    IDLE: begin
                        if (r_data == SYNC_BYTE) begin
                            state <= PAYLOAD;
                            busy  <= 1'b1;
                            idx   <= '0;
                            csum  <= '0;
                        end
                    end
                    PAYLOAD: begin
                        // A sync value here is ordinary data; there is no resync.
                        for (int i = 0; i < PAYLOAD_BYTES; i++) begin
                            if (idx == IDX_W'(i)) begin
                                shadow[8*i +: 8] <= r_data;
                            end
                        end
                        csum <= xor_update(csum, r_data);
                        if (idx == LAST_IDX) begin
                            state <= CHECK;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                    CHECK: begin
                        if (r_data == csum) begin
                            frame_data  <= shadow;
                            frame_valid <= 1'b1;
                        end else begin
                            chk_err <= 1'b1;
                        end
                        state <= IDLE;
                        busy  <= 1'b0;
                        idx   <= '0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end else if (tmo_fire) begin
                state   <= IDLE;
                busy    <= 1'b0;
                chk_err <= 1'b1;
                idx     <= '0;
                csum    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb/tb_uart_frame_rx.sv - directed self-checking bench for uart_frame_rx
module tb_uart_frame_rx;

    logic        clk;
    logic        rst;
    logic        rx_empty;
    logic [7:0]  r_data;
    logic        rd_uart;
    logic [31:0] frame_data;
    logic        frame_valid;
    logic        chk_err;
    logic        busy;

    int total = 0;
    int bad   = 0;

    uart_frame_rx #(
        .PAYLOAD_BYTES(4),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT_CYC(50)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_empty(rx_empty),
        .r_data(r_data),
        .rd_uart(rd_uart),
        .frame_data(frame_data),
        .frame_valid(frame_valid),
        .chk_err(chk_err),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one byte, let it be popped on the next edge, sample 1 time unit later.
    task automatic send(input logic [7:0] b);
        rx_empty = 1'b0;
        r_data   = b;
        @(posedge clk);
        #1;
        rx_empty = 1'b1;
    endtask

    task automatic idle_tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seen;
        rst      = 1'b1;
        rx_empty = 1'b1;
        r_data   = 8'h00;
        idle_tick();
        idle_tick();
        check("reset_frame_data", frame_data, 32'h0);
        check("reset_valid", {31'b0, frame_valid}, 32'h0);
        check("reset_chk_err", {31'b0, chk_err}, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h0);
        rst = 1'b0;
        #1;
        check("rd_idle_empty", {31'b0, rd_uart}, 32'h0);

        // 1: good frame, checksum 11^22^33^44 = 44
        send(8'hA5);
        check("t1_busy_after_sync", {31'b0, busy}, 32'h1);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        check("t1_no_valid_early", {31'b0, frame_valid}, 32'h0);
        send(8'h44);
        check("t1_valid", {31'b0, frame_valid}, 32'h1);
        check("t1_data", frame_data, 32'h44332211);
        check("t1_no_err", {31'b0, chk_err}, 32'h0);
        check("t1_busy_low", {31'b0, busy}, 32'h0);
        idle_tick();
        check("t1_valid_one_cycle", {31'b0, frame_valid}, 32'h0);
        check("t1_data_hold", frame_data, 32'h44332211);

        // 2: bad checksum (expected 04)
        send(8'hA5); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'hFF);
        check("t2_err", {31'b0, chk_err}, 32'h1);
        check("t2_no_valid", {31'b0, frame_valid}, 32'h0);
        check("t2_data_kept", frame_data, 32'h44332211);
        idle_tick();
        check("t2_err_one_cycle", {31'b0, chk_err}, 32'h0);

        // 3: garbage before sync
        send(8'h00);
        send(8'h7E);
        check("t3_garbage_idle", {31'b0, busy}, 32'h0);
        send(8'hA5); send(8'h01); send(8'h00); send(8'h00); send(8'h00);
        send(8'h01);
        check("t3_valid", {31'b0, frame_valid}, 32'h1);
        check("t3_data", frame_data, 32'h00000001);

        // 4: sync value inside payload, back-to-back with previous frame
        send(8'hA5); send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
        send(8'hA5);
        check("t4_valid", {31'b0, frame_valid}, 32'h1);
        check("t4_data", frame_data, 32'h000000A5);
        check("t4_no_err", {31'b0, chk_err}, 32'h0);

        // 5: reset mid-frame, with a byte waiting during reset
        send(8'hA5); send(8'h01); send(8'h02);
        rst      = 1'b1;
        rx_empty = 1'b0;
        r_data   = 8'h03;
        #1;
        check("t5_rd_blocked_in_rst", {31'b0, rd_uart}, 32'h0);
        idle_tick();
        check("t5_rst_data", frame_data, 32'h0);
        check("t5_rst_busy", {31'b0, busy}, 32'h0);
        check("t5_rst_valid", {31'b0, frame_valid}, 32'h0);
        rst      = 1'b0;
        rx_empty = 1'b1;
        idle_tick();
        check("t5_after_rst_data", frame_data, 32'h0);
        check("t5_after_rst_err", {31'b0, chk_err}, 32'h0);
        send(8'hA5); send(8'h10); send(8'h20); send(8'h30); send(8'h40);
        send(8'h40);
        check("t5_valid", {31'b0, frame_valid}, 32'h1);
        check("t5_data", frame_data, 32'h40302010);

`ifdef UART_FRAME_RX_TIMEOUT_EN
        // 6: timeout after 50 idle cycles mid-frame
        send(8'hA5); send(8'h01);
        seen = 0;
        for (int c = 1; c <= 80; c++) begin
            idle_tick();
            if (chk_err && seen == 0) seen = c;
        end
        check("t6_timeout_cycle", 32'(seen), 32'd50);
        check("t6_busy_low", {31'b0, busy}, 32'h0);
        send(8'hA5); send(8'h0A); send(8'h0B); send(8'h0C); send(8'h0D);
        send(8'h00);
        check("t6_valid", {31'b0, frame_valid}, 32'h1);
        check("t6_data", frame_data, 32'h0D0C0B0A);
`else
        // Without the timeout, a stalled frame must stay busy.
        send(8'hA5); send(8'h01);
        seen = 0;
        for (int c = 1; c <= 80; c++) begin
            idle_tick();
            if (chk_err) seen = c;
        end
        check("t6_no_timeout_err", 32'(seen), 32'd0);
        check("t6_still_busy", {31'b0, busy}, 32'h1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
